// File: rtl/d_mem_pkg.sv
// Shared encodings and MMIO word-offset map for the data-memory front end.
package d_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  function automatic int OFF_OUT(input int k);
    return k;
  endfunction

  function automatic int OFF_IN(input int num_out, input int j);
    return num_out + j;
  endfunction

  function automatic int OFF_STATUS(input int num_out, input int num_in);
    return num_out + num_in;
  endfunction

  function automatic int OFF_CNT(input int num_out, input int num_in);
    return num_out + num_in + 1;
  endfunction

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-stage synchroniser for one input word, flagging when the settled value moves.
module io_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             changed_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign sync_o    = stage_q[STAGES-1];
  assign changed_o = (stage_q[STAGES-1] != prev_q);

endmodule

// File: rtl/mem.sv
// Byte-addressable data RAM with lane-masked stores and extending loads.
module mem
  import d_mem_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH     = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(DEPTH)+1:0]   addr_i,
  input  logic [BUS_WIDTH-1:0]       wr_data_i,
  input  logic                       wr_en_i,
  input  logic [1:0]                 size_i,
  input  logic                       sz_ex_i,
  output logic [BUS_WIDTH-1:0]       rd_data_o
);

  logic [BUS_WIDTH-1:0] ram_q [DEPTH];
  logic [BUS_WIDTH-1:0] mask, data, word;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mask = '0;
    data = '0;
    case (size_i)
      SZ_BYTE: begin
        mask[{addr_i[1:0], 3'b000} +: 8] = 8'hFF;
        data[{addr_i[1:0], 3'b000} +: 8] = wr_data_i[7:0];
      end
      SZ_HALF: begin
        mask[{addr_i[1], 4'b0000} +: 16] = 16'hFFFF;
        data[{addr_i[1], 4'b0000} +: 16] = wr_data_i[15:0];
      end
      default: begin
        mask = '1;
        data = wr_data_i;
      end
    endcase
  end

  // NOTE: the array is cleared by reset so loads after rst return known zeros.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else if (wr_en_i) begin
      ram_q[addr_i[$clog2(DEPTH)+1:2]] <= (ram_q[addr_i[$clog2(DEPTH)+1:2]] & ~mask) | (data & mask);
    end
  end

  assign word   = ram_q[addr_i[$clog2(DEPTH)+1:2]];
  assign byte_v = word[{addr_i[1:0], 3'b000} +: 8];
  assign half_v = word[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    case (size_i)
      SZ_BYTE: rd_data_o = {{(BUS_WIDTH-8){sz_ex_i & byte_v[7]}}, byte_v};
      SZ_HALF: rd_data_o = {{(BUS_WIDTH-16){sz_ex_i & half_v[15]}}, half_v};
      default: rd_data_o = word;
    endcase
  end

endmodule

// File: rtl/d_mem_mmio.sv
// Data-memory front end: decodes the MMIO window (OUT, IN, STATUS, CNT) and routes the rest to RAM.
module d_mem_mmio
  import d_mem_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int MMIO_BASE   = 256,
  parameter int NUM_OUT     = 4,
  parameter int NUM_IN      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int RAM_WORDS   = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BUS_WIDTH-1:0]          d_mem_address,
  input  logic [BUS_WIDTH-1:0]          d_mem_wr_data,
  input  logic                          d_mem_wr_en,
  input  logic [1:0]                    d_mem_size,
  input  logic                          d_mem_sz_ex,
  input  logic [NUM_IN*BUS_WIDTH-1:0]   io_in,
  output logic [BUS_WIDTH-1:0]          d_mem_rd_data,
  output logic [NUM_OUT*BUS_WIDTH-1:0]  mmio_out,
  output logic                          d_mem_misalign
);

  localparam int RAM_AW = $clog2(RAM_WORDS) + 2;
  localparam logic [BUS_WIDTH-1:0] BASE_A   = BUS_WIDTH'(MMIO_BASE);
  localparam logic [BUS_WIDTH-1:0] END_A    = BUS_WIDTH'(MMIO_BASE + 4 * (NUM_OUT + NUM_IN + 2));
  localparam logic [BUS_WIDTH-1:0] STATUS_W = BUS_WIDTH'(OFF_STATUS(NUM_OUT, NUM_IN));
  localparam logic [BUS_WIDTH-1:0] CNT_W    = BUS_WIDTH'(OFF_CNT(NUM_OUT, NUM_IN));

  logic [BUS_WIDTH-1:0] out_q [NUM_OUT];
  logic [BUS_WIDTH-1:0] out_d [NUM_OUT];
  logic [NUM_IN-1:0]    flags_q, flags_d, status_clr, in_changed;
  logic [BUS_WIDTH-1:0] cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] in_sync [NUM_IN];

  logic                 in_mmio, mmio_we, ram_we;
  logic [BUS_WIDTH-1:0] word_off, lane_mask, lane_data, sel_word, mmio_rd, ram_rd;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;

  assign d_mem_misalign = is_misaligned(d_mem_size, d_mem_address[1:0]);
  assign in_mmio  = (d_mem_address >= BASE_A) && (d_mem_address < END_A);
  assign word_off = (d_mem_address - BASE_A) >> 2;
  assign mmio_we  = d_mem_wr_en && in_mmio && !d_mem_misalign;
  assign ram_we   = d_mem_wr_en && !in_mmio && !d_mem_misalign;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_sync #(.WIDTH(BUS_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
      .clk_i     (clk),
      .rst_i     (rst),
      .async_i   (io_in[g*BUS_WIDTH +: BUS_WIDTH]),
      .sync_o    (in_sync[g]),
      .changed_o (in_changed[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign mmio_out[g*BUS_WIDTH +: BUS_WIDTH] = out_q[g];
  end

  mem #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(RAM_WORDS)) u_mem (
    .clk_i     (clk),
    .rst_i     (rst),
    .addr_i    (d_mem_address[RAM_AW-1:0]),
    .wr_data_i (d_mem_wr_data),
    .wr_en_i   (ram_we),
    .size_i    (d_mem_size),
    .sz_ex_i   (d_mem_sz_ex),
    .rd_data_o (ram_rd)
  );

  // Store data shifted into its byte/half lane, with a mask of the bytes it covers.
  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    case (d_mem_size)
      SZ_BYTE: begin
        lane_mask[{d_mem_address[1:0], 3'b000} +: 8] = 8'hFF;
        lane_data[{d_mem_address[1:0], 3'b000} +: 8] = d_mem_wr_data[7:0];
      end
      SZ_HALF: begin
        lane_mask[{d_mem_address[1], 4'b0000} +: 16] = 16'hFFFF;
        lane_data[{d_mem_address[1], 4'b0000} +: 16] = d_mem_wr_data[15:0];
      end
      default: begin
        lane_mask = '1;
        lane_data = d_mem_wr_data;
      end
    endcase
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_OUT; k++)
      if (word_off == BUS_WIDTH'(OFF_OUT(k))) sel_word = out_q[k];
    for (int j = 0; j < NUM_IN; j++)
      if (word_off == BUS_WIDTH'(OFF_IN(NUM_OUT, j))) sel_word = in_sync[j];
    if (word_off == STATUS_W) sel_word = BUS_WIDTH'(flags_q);
    if (word_off == CNT_W)    sel_word = cnt_q;
  end

  assign byte_v = sel_word[{d_mem_address[1:0], 3'b000} +: 8];
  assign half_v = sel_word[{d_mem_address[1], 4'b0000} +: 16];

  always_comb begin
    case (d_mem_size)
      SZ_BYTE: mmio_rd = {{(BUS_WIDTH-8){d_mem_sz_ex & byte_v[7]}}, byte_v};
      SZ_HALF: mmio_rd = {{(BUS_WIDTH-16){d_mem_sz_ex & half_v[15]}}, half_v};
      default: mmio_rd = sel_word;
    endcase
  end

  assign d_mem_rd_data = d_mem_misalign ? '0 : (in_mmio ? mmio_rd : ram_rd);

  // A flag set in the same cycle as its W1C clear survives.
  always_comb begin
    status_clr = '0;
    cnt_d      = cnt_q + 1'b1;
    for (int k = 0; k < NUM_OUT; k++) out_d[k] = out_q[k];
    if (mmio_we) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (word_off == BUS_WIDTH'(OFF_OUT(k)))
          out_d[k] = (out_q[k] & ~lane_mask) | (lane_data & lane_mask);
      if (word_off == STATUS_W) status_clr = lane_data[NUM_IN-1:0] & lane_mask[NUM_IN-1:0];
      if (word_off == CNT_W && d_mem_size[1]) cnt_d = d_mem_wr_data;
    end
    flags_d = (flags_q & ~status_clr) | in_changed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= out_d[k];
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_d_mem_mmio.sv
// Randomised bench for d_mem_mmio against a byte-level model of the memory map.
`timescale 1ns/1ps
module tb_d_mem_mmio;

  localparam int BASE = 256;
  localparam int WEND = 288;
  localparam logic [31:0] OUT0 = 32'd256, IN0 = 32'd272, STAT = 32'd280, CNT = 32'd284;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_mem_address = '0, d_mem_wr_data = '0;
  logic        d_mem_wr_en = 1'b0, d_mem_sz_ex = 1'b0;
  logic [1:0]  d_mem_size = 2'b10;
  logic [63:0] io_in = '0;
  logic [31:0] d_mem_rd_data;
  logic [127:0] mmio_out;
  logic        d_mem_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  d_mem_mmio dut (
    .clk(clk), .rst(rst), .d_mem_address(d_mem_address), .d_mem_wr_data(d_mem_wr_data),
    .d_mem_wr_en(d_mem_wr_en), .d_mem_size(d_mem_size), .d_mem_sz_ex(d_mem_sz_ex),
    .io_in(io_in), .d_mem_rd_data(d_mem_rd_data), .mmio_out(mmio_out),
    .d_mem_misalign(d_mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_out [4];
  logic [63:0] m_h0, m_h1, m_h2;   // io_in samples from the last three edges, newest first
  logic [1:0]  m_flags;
  logic [31:0] m_cnt;
  logic [7:0]  m_ram [512];
  bit          m_valid = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < WEND);
  endfunction

  function automatic logic [31:0] mmio_word(input int off);
    if (off < 4)  return m_out[off];
    if (off == 4) return m_h1[31:0];
    if (off == 5) return m_h1[63:32];
    if (off == 6) return {30'd0, m_flags};
    return m_cnt;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input int nb, input logic sx);
    logic [31:0] mask;
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 1;
    if (sx && v[8*nb-1]) return (v & mask) | ~mask;
    return v & mask;
  endfunction

  function automatic logic [31:0] exp_rd();
    int nb, a;
    logic [31:0] v;
    nb = nbytes(d_mem_size);
    a  = int'(d_mem_address);
    if (misal(d_mem_address, d_mem_size)) return '0;
    if (in_win(d_mem_address)) begin
      v = mmio_word((a - BASE) / 4) >> (8 * (a % 4));
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(m_ram[a+i]) << (8 * i));
    end
    return extend(v, nb, d_mem_sz_ex);
  endfunction

  always @(posedge clk) begin
    int nb, a, off, p;
    logic [7:0] b;
    logic [1:0] nf;
    bit loaded;
    if (rst) begin
      for (int k = 0; k < 4; k++) m_out[k] = '0;
      for (int i = 0; i < 512; i++) m_ram[i] = '0;
      m_h0 = '0; m_h1 = '0; m_h2 = '0;
      m_flags = '0; m_cnt = '0;
      m_valid = 1;
    end else if (m_valid) begin
      nb = nbytes(d_mem_size);
      a  = int'(d_mem_address);
      nf = m_flags;
      loaded = 0;
      if (d_mem_wr_en && !misal(d_mem_address, d_mem_size)) begin
        for (int i = 0; i < nb; i++) begin
          b = d_mem_wr_data[8*i +: 8];
          if (in_win(d_mem_address)) begin
            off = (a - BASE) / 4;
            p   = (a % 4) + i;
            if (off < 4) m_out[off][8*p +: 8] = b;
            else if (off == 6 && p == 0) nf = nf & ~b[1:0];
            else if (off == 7 && nb == 4) loaded = 1;
          end else begin
            m_ram[a+i] = b;
          end
        end
      end
      for (int j = 0; j < 2; j++)
        if (m_h1[32*j +: 32] != m_h2[32*j +: 32]) nf[j] = 1'b1;
      m_flags = nf;
      m_cnt   = loaded ? d_mem_wr_data : m_cnt + 1;
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = io_in;
    end
  end

  // Every cycle, compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("rd_data", d_mem_rd_data, exp_rd());
      check("misalign", 32'(d_mem_misalign), 32'(misal(d_mem_address, d_mem_size)));
      for (int k = 0; k < 4; k++)
        check($sformatf("mmio_out%0d", k), mmio_out[32*k +: 32], m_out[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [1:0] sz, input logic ex, input logic r);
    @(posedge clk);
    #1;
    d_mem_address = a; d_mem_wr_data = d; d_mem_wr_en = we;
    d_mem_size = sz; d_mem_sz_ex = ex; rst = r;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, RAM write, then reset again: RAM clears, CNT reads 0 in the reset cycle.
    step(0, 0, 0, 2'b10, 0, 1);
    step(0, 0, 0, 2'b10, 0, 1);
    step(16, 32'hCAFEF00D, 1, 2'b10, 0, 0);
    step(16, 0, 0, 2'b10, 0, 0);       check("ram_before_reset", d_mem_rd_data, 32'hCAFEF00D);
    step(16, 0, 0, 2'b10, 0, 1);
    step(CNT, 0, 0, 2'b10, 0, 1);      check("cnt_in_reset", d_mem_rd_data, 32'h0);
    step(16, 0, 0, 2'b10, 0, 0);       check("ram_after_reset", d_mem_rd_data, 32'h0);
    for (int k = 0; k < 7; k++) begin
      step(OUT0 + 32'(4 * k), 0, 0, 2'b10, 0, 0);
      check($sformatf("reset_reg%0d", k), d_mem_rd_data, 32'h0);
    end

    // Word then byte store into OUT[1], signed/unsigned byte loads.
    step(260, 32'hDEADBEEF, 1, 2'b10, 0, 0);
    step(262, 32'h00000012, 1, 2'b00, 0, 0);
    step(260, 0, 0, 2'b10, 0, 0);      check("out1_merge", mmio_out[63:32], 32'hDE12BEEF);
    step(263, 0, 0, 2'b00, 1, 0);      check("lb_signed", d_mem_rd_data, 32'hFFFFFFDE);
    step(263, 0, 0, 2'b00, 0, 0);      check("lb_unsigned", d_mem_rd_data, 32'h000000DE);

    // Input synchroniser latency, change flag, W1C, and set-beats-clear.
    io_in[31:0] = 32'h5;
    step(IN0, 0, 0, 2'b10, 0, 0);      check("in0_after1", d_mem_rd_data, 32'h0);
    step(IN0, 0, 0, 2'b10, 0, 0);      check("in0_after2", d_mem_rd_data, 32'h5);
    step(STAT, 0, 0, 2'b10, 0, 0);     check("status_set", d_mem_rd_data, 32'h1);
    step(STAT, 1, 1, 2'b10, 0, 0);
    step(STAT, 0, 0, 2'b10, 0, 0);     check("status_w1c", d_mem_rd_data, 32'h0);
    io_in[31:0] = 32'h6;
    step(STAT, 0, 0, 2'b10, 0, 0);
    step(STAT, 1, 1, 2'b10, 0, 0);
    step(STAT, 0, 0, 2'b10, 0, 0);     check("status_set_wins", d_mem_rd_data, 32'h1);
    step(STAT, 1, 1, 2'b10, 0, 0);
    step(STAT, 0, 0, 2'b10, 0, 0);     check("status_cleared", d_mem_rd_data, 32'h0);

    // Counter load, wrap, and ignored half write.
    step(CNT, 32'hFFFFFFFE, 1, 2'b10, 0, 0);
    step(CNT, 0, 0, 2'b10, 0, 0);      check("cnt_load", d_mem_rd_data, 32'hFFFFFFFE);
    step(CNT, 0, 0, 2'b10, 0, 0);      check("cnt_max", d_mem_rd_data, 32'hFFFFFFFF);
    step(CNT, 0, 0, 2'b10, 0, 0);      check("cnt_wrap", d_mem_rd_data, 32'h0);
    step(CNT, 32'h1234, 1, 2'b01, 0, 0);
    step(CNT, 0, 0, 2'b10, 0, 0);      check("cnt_half_ignored", d_mem_rd_data, 32'h2);

    // Misalignment and window edges.
    step(258, 32'hAAAA5555, 1, 2'b10, 0, 0);
    check("misalign_word", 32'(d_mem_misalign), 32'h1);
    check("misalign_word_rd", d_mem_rd_data, 32'h0);
    step(257, 0, 0, 2'b01, 0, 0);      check("misalign_half", 32'(d_mem_misalign), 32'h1);
    check("out0_untouched", mmio_out[31:0], 32'h0);
    step(255, 32'h77, 1, 2'b00, 0, 0);
    step(255, 0, 0, 2'b00, 0, 0);      check("below_window_ram", d_mem_rd_data, 32'h77);
    check("out3_untouched", mmio_out[127:96], 32'h0);
    step(288, 32'h13579BDF, 1, 2'b10, 0, 0);
    step(288, 0, 0, 2'b10, 0, 0);      check("above_window_ram", d_mem_rd_data, 32'h13579BDF);

    // Read-only IN, and reset overriding a same-cycle write.
    step(IN0, 32'hFFFF, 1, 2'b10, 0, 0);
    step(IN0, 0, 0, 2'b10, 0, 0);      check("in0_read_only", d_mem_rd_data, 32'h6);
    step(OUT0, 32'h11111111, 1, 2'b10, 0, 1);
    step(OUT0, 0, 0, 2'b10, 0, 0);     check("rst_beats_write", mmio_out[31:0], 32'h0);

    // Randomised traffic concentrated around the window.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) begin
        int j;
        j = $urandom_range(0, 1);
        io_in[32*j +: 32] = $urandom;
      end
      a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 507)) : 32'($urandom_range(240, 300));
      step(a, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
